// File: rtl/calc_pkg.sv
// Shared definitions for the calculator's button path: classifier states
// and the default 25 MHz timing constants every button instance uses.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_WAIT_SECOND,
    ST_WAIT_RELEASE
  } btn_state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_SHORT,
    EV_DOUBLE,
    EV_LONG,
    EV_REPEAT
  } btn_event_t;

  localparam int LONG_CYCLES_25M   = 25_000_000;
  localparam int DBL_WINDOW_25M    = 7_500_000;
  localparam int REPEAT_CYCLES_25M = 5_000_000;
  localparam int BTN_CNT_W         = 25;

endpackage

// File: rtl/button_event_classifier.sv
// Classifies debounced active-low presses into short, double, long and
// auto-repeat strobes for the menu/input FSM; one instance per button.
module button_event_classifier
  import calc_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_25M,
  parameter int DBL_WINDOW    = DBL_WINDOW_25M,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_25M,
  parameter bit EN_DOUBLE     = 1'b1,
  parameter int CNT_W         = BTN_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAST_LONG = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_DBL  = CNT_W'(DBL_WINDOW - 1);
  localparam logic [CNT_W-1:0] LAST_REP  = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state, state_next;
  btn_event_t       event_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             armed, armed_next;

  // armed stays low after reset until the button has been seen released,
  // so a press already in progress at reset never produces an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      armed        <= 1'b0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      armed        <= armed_next;
      short_pulse  <= (event_next == EV_SHORT);
      double_pulse <= (event_next == EV_DOUBLE);
      long_pulse   <= (event_next == EV_LONG);
      repeat_pulse <= (event_next == EV_REPEAT);
      busy         <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    armed_next = armed;
    event_next = EV_NONE;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (!armed) begin
          armed_next = btn_level;
        end else if (!btn_level) begin
          state_next = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (btn_level) begin
          cnt_next = '0;
          if (EN_DOUBLE) begin
            state_next = ST_WAIT_SECOND;
          end else begin
            state_next = ST_IDLE;
            event_next = EV_SHORT;
          end
        end else if (cnt == LAST_LONG) begin
          cnt_next   = '0;
          state_next = ST_LONG_HELD;
          event_next = EV_LONG;
        end
      end
      ST_LONG_HELD: begin
        if (btn_level) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else if (cnt == LAST_REP) begin
          cnt_next   = '0;
          event_next = EV_REPEAT;
        end
      end
      // A press landing on the last window cycle still wins as a double.
      ST_WAIT_SECOND: begin
        if (!btn_level) begin
          cnt_next   = '0;
          state_next = ST_WAIT_RELEASE;
          event_next = EV_DOUBLE;
        end else if (cnt == LAST_DBL) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
          event_next = EV_SHORT;
        end
      end
      ST_WAIT_RELEASE: begin
        cnt_next = '0;
        if (btn_level) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// Scoreboard bench: a press-run reference model predicts strobes and busy for
// a double-click instance and a short-only instance driven by the same level.
module tb_button_event_classifier;
  import calc_pkg::*;

  localparam int L = 20;
  localparam int D = 10;
  localparam int R = 5;
  localparam int CW = 5;
  localparam int MAXN = 8192;
  localparam int K_SHORT = 1;
  localparam int K_DOUBLE = 2;
  localparam int K_LONG = 3;
  localparam int K_REPEAT = 4;

  typedef struct {
    int edgeIdx;
    int kind;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b1;
  logic short0, double0, long0, repeat0, busy0;
  logic short1, double1, long1, repeat1, busy1;

  bit lvArr[$];
  bit rsArr[$];
  int numCycles;
  int expEv[2][MAXN];
  bit expBusy[2][MAXN];
  sb_entry_t sbq0[$];
  sb_entry_t sbq1[$];
  int drvIdx = -1;
  int checks = 0;
  int errors = 0;

  button_event_classifier #(
    .LONG_CYCLES(L), .DBL_WINDOW(D), .REPEAT_CYCLES(R), .EN_DOUBLE(1'b1), .CNT_W(CW)
  ) dutDbl (
    .clk(clk), .rst(rst), .btn_level(btn_level),
    .short_pulse(short0), .double_pulse(double0), .long_pulse(long0),
    .repeat_pulse(repeat0), .busy(busy0)
  );

  button_event_classifier #(
    .LONG_CYCLES(L), .DBL_WINDOW(D), .REPEAT_CYCLES(R), .EN_DOUBLE(1'b0), .CNT_W(CW)
  ) dutSgl (
    .clk(clk), .rst(rst), .btn_level(btn_level),
    .short_pulse(short1), .double_pulse(double1), .long_pulse(long1),
    .repeat_pulse(repeat1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic addLevel(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      lvArr.push_back(v);
      rsArr.push_back(1'b0);
    end
  endtask

  task automatic addReset(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      lvArr.push_back(v);
      rsArr.push_back(1'b1);
    end
  endtask

  function automatic int nextIdx(input int a, input int e, input bit v);
    for (int i = a; i < e; i++) begin
      if (lvArr[i] == v) return i;
    end
    return e;
  endfunction

  function automatic void markBusy(input int inst, input int a, input int b, input int e);
    for (int i = a; i < b && i < e; i++) expBusy[inst][i] = 1'b1;
  endfunction

  // Works on whole press/release runs: hold length decides long vs short,
  // release-to-press distance decides double vs short.
  function automatic void modelSegment(input int inst, input bit en, input int s, input int e);
    int t, t0, r, p, r2;
    t = nextIdx(s, e, 1'b1) + 1;
    while (t < e) begin
      if (lvArr[t]) begin
        t++;
        continue;
      end
      t0 = t;
      r = nextIdx(t0 + 1, e, 1'b1);
      markBusy(inst, t0, r, e);
      if (r - t0 > L) begin
        expEv[inst][t0 + L] = K_LONG;
        for (int k = t0 + L + R; k < r; k += R) expEv[inst][k] = K_REPEAT;
        t = r + 1;
        continue;
      end
      if (r >= e) break;
      if (!en) begin
        expEv[inst][r] = K_SHORT;
        t = r + 1;
        continue;
      end
      p = nextIdx(r + 1, e, 1'b0);
      if (p - r <= D) begin
        markBusy(inst, r, p, e);
        if (p >= e) break;
        expEv[inst][p] = K_DOUBLE;
        r2 = nextIdx(p + 1, e, 1'b1);
        markBusy(inst, p, r2, e);
        t = r2 + 1;
      end else begin
        markBusy(inst, r, r + D, e);
        if (r + D >= e) break;
        expEv[inst][r + D] = K_SHORT;
        t = r + D + 1;
      end
    end
  endfunction

  function automatic void buildModel(input int inst, input bit en);
    int s, e;
    for (int i = 0; i < MAXN; i++) begin
      expEv[inst][i] = 0;
      expBusy[inst][i] = 1'b0;
    end
    s = 0;
    while (s < numCycles) begin
      if (rsArr[s]) begin
        s++;
        continue;
      end
      e = s;
      while (e < numCycles && !rsArr[e]) e++;
      modelSegment(inst, en, s, e);
      s = e;
    end
  endfunction

  function automatic bit sbEmpty(input int inst);
    return (inst == 0) ? (sbq0.size() == 0) : (sbq1.size() == 0);
  endfunction

  function automatic sb_entry_t sbFront(input int inst);
    return (inst == 0) ? sbq0[0] : sbq1[0];
  endfunction

  function automatic void sbPop(input int inst);
    if (inst == 0) void'(sbq0.pop_front());
    else void'(sbq1.pop_front());
  endfunction

  task automatic checkOutput(input int inst, input int c);
    logic [3:0] s;
    logic b;
    int kind;
    sb_entry_t f;
    s = (inst == 0) ? {repeat0, long0, double0, short0} : {repeat1, long1, double1, short1};
    b = (inst == 0) ? busy0 : busy1;
    checks++;
    if (b !== expBusy[inst][c]) begin
      errors++;
      $display("[TB] FAIL busy inst%0d edge %0d: got %b expected %b", inst, c, b, expBusy[inst][c]);
    end
    checks++;
    if ($countones(s) > 1 || $isunknown(s)) begin
      errors++;
      $display("[TB] FAIL onehot inst%0d edge %0d: got strobes %b expected at most one", inst, c, s);
    end
    while (!sbEmpty(inst)) begin
      f = sbFront(inst);
      if (f.edgeIdx >= c) break;
      checks++;
      errors++;
      $display("[TB] FAIL missing inst%0d: got no strobe at edge %0d expected kind %0d", inst, f.edgeIdx, f.kind);
      sbPop(inst);
    end
    if (s != 4'b0000) begin
      kind = s[0] ? K_SHORT : s[1] ? K_DOUBLE : s[2] ? K_LONG : K_REPEAT;
      checks++;
      if (sbEmpty(inst)) begin
        errors++;
        $display("[TB] FAIL unexpected inst%0d edge %0d: got kind %0d expected none", inst, c, kind);
      end else begin
        f = sbFront(inst);
        if (f.edgeIdx != c) begin
          errors++;
          $display("[TB] FAIL timing inst%0d: got kind %0d at edge %0d expected kind %0d at edge %0d",
                   inst, kind, c, f.kind, f.edgeIdx);
        end else begin
          if (kind != f.kind) begin
            errors++;
            $display("[TB] FAIL kind inst%0d edge %0d: got %0d expected %0d", inst, c, kind, f.kind);
          end
          sbPop(inst);
        end
      end
    end
  endtask

  task automatic applyStimulus();
    for (int c = 0; c < numCycles; c++) begin
      @(negedge clk);
      rst = rsArr[c];
      btn_level = lvArr[c];
      if (expEv[0][c] != 0) sbq0.push_back('{c, expEv[0][c]});
      if (expEv[1][c] != 0) sbq1.push_back('{c, expEv[1][c]});
      drvIdx = c;
    end
    @(negedge clk);
    drvIdx = -1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drvIdx >= 0) begin
        checkOutput(0, drvIdx);
        checkOutput(1, drvIdx);
      end
    end
  end

  initial begin
    addReset(1'b1, 3);
    addLevel(1'b1, 3);
    addLevel(1'b0, 5);  addLevel(1'b1, 15);
    addLevel(1'b0, 5);  addLevel(1'b1, 4);  addLevel(1'b0, 5);  addLevel(1'b1, 15);
    addLevel(1'b0, 38); addLevel(1'b1, 15);
    addLevel(1'b0, 5);  addLevel(1'b1, 10); addLevel(1'b0, 5);  addLevel(1'b1, 15);
    addLevel(1'b0, 5);  addLevel(1'b1, 11); addLevel(1'b0, 5);  addLevel(1'b1, 15);
    addLevel(1'b0, 10); addReset(1'b0, 2);  addLevel(1'b0, 30); addLevel(1'b1, 15);
    addLevel(1'b0, 5);  addLevel(1'b1, 15);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9) == 0) addReset(1'($urandom_range(1)), $urandom_range(3, 1));
      addLevel(1'b0, $urandom_range(45, 1));
      addLevel(1'b1, $urandom_range(16, 1));
    end
    addLevel(1'b1, 20);
    numCycles = lvArr.size();
    buildModel(0, 1'b1);
    buildModel(1, 1'b0);
    $display("[TB] driving %0d cycles", numCycles);
    applyStimulus();
    repeat (2) @(negedge clk);
    checks++;
    if (sbq0.size() != 0 || sbq1.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d/%0d unseen events expected 0/0", sbq0.size(), sbq1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
